alu_share_arbiter: RTL and testbench

//   Shares one 4-bit ALU datapath (opcodes 0-12) among NUM_REQ requesters.

---
 rtl/alu_share_arbiter.sv | 166 ++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one 4-bit ALU among NUM_REQ
// requesters, with a registered, error-flagged response channel.
module alu_share_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [4*NUM_REQ-1:0] req_op,
    input  logic [4*NUM_REQ-1:0] req_a,
    input  logic [4*NUM_REQ-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [7:0]           rsp_data,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 rsp_err,
    output logic                 busy
);

    localparam int unsigned OP_W  = 4;
    localparam int unsigned RES_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
        logic [ID_W-1:0] id;
    } cmd_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    cmd_t               cmd_q, cmd_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [RES_W-1:0]   rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic               rsp_err_q, rsp_err_d;

    logic               grant_found;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W-1:0]    scan_idx;
    logic [NUM_REQ-1:0] req_ready_c;
    logic [RES_W-1:0]   alu_data;
    logic               alu_err;
    logic [RES_W-1:0]   a8, b8;

    // Round-robin search: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_idx = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    // ALU on the captured command; zero-extended 8-bit arithmetic.
    always_comb begin
        a8       = {4'h0, cmd_q.a};
        b8       = {4'h0, cmd_q.b};
        alu_data = '0;
        alu_err  = 1'b0;
        case (cmd_q.op)
            4'd0:  alu_data = a8 + b8;
            4'd1:  alu_data = a8 - b8;
            4'd2:  alu_data = a8 * b8;
            4'd3: begin
                if (cmd_q.b == 4'd0) alu_err  = 1'b1;
                else                 alu_data = a8 / b8;
            end
            4'd4: begin
                if (cmd_q.b == 4'd0) alu_err  = 1'b1;
                else                 alu_data = a8 % b8;
            end
            4'd5:  alu_data = a8 & b8;
            4'd6:  alu_data = a8 | b8;
            4'd7:  alu_data = a8 ^ b8;
            4'd8:  alu_data = {4'h0, ~(cmd_q.a ^ cmd_q.b)};
            4'd9:  alu_data = {4'h0, ~cmd_q.a};
            4'd10: alu_data = {4'h0, ~cmd_q.b};
            4'd11: alu_data = (cmd_q.b >= 4'd8) ? '0 : (a8 << cmd_q.b);
            4'd12: alu_data = a8 >> cmd_q.b;
            default: alu_err = 1'b1;
        endcase
    end

    // FSM next-state, capture and response logic.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cmd_d       = cmd_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        rsp_err_d   = rsp_err_q;
        req_ready_c = '0;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    req_ready_c = NUM_REQ'(1) << grant_idx;
                    cmd_d.op    = req_op[OP_W*grant_idx +: OP_W];
                    cmd_d.a     = req_a[OP_W*grant_idx +: OP_W];
                    cmd_d.b     = req_b[OP_W*grant_idx +: OP_W];
                    cmd_d.id    = grant_idx;
                    rr_ptr_d    = ID_W'((32'(grant_idx) + 1) % NUM_REQ);
                    state_d     = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d  = alu_data;
                rsp_err_d   = alu_err;
                rsp_id_d    = cmd_q.id;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any command in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            cmd_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cmd_q       <= cmd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Grant is suppressed while reset is held.
    assign req_ready = req_ready_c & {NUM_REQ{rst_n}};
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with 4 requesters.
module tb_alu_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic [1:0]  rsp_id;
    logic        rsp_err;
    logic        busy;

    int n_total = 0;
    int n_bad   = 0;

    alu_share_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-requester command; returns the observed response fields.
    task automatic issue(input int i, input logic [3:0] op, input logic [3:0] a,
                         input logic [3:0] b, output logic [7:0] d,
                         output logic e, output logic [1:0] id);
        int n;
        @(negedge clk);
        req_op[4*i +: 4] = op;
        req_a[4*i +: 4]  = a;
        req_b[4*i +: 4]  = b;
        req_valid        = 4'b0000;
        req_valid[i]     = 1'b1;
        rsp_ready        = 1'b1;
        #1;
        n = 0;
        while (req_ready == 4'b0000 && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) begin
            n_bad++;
            $display("FAIL grant_timeout req=%0d got req_ready=%b want nonzero", i, req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) begin
            n_bad++;
            $display("FAIL rsp_timeout req=%0d got rsp_valid=%b want 1", i, rsp_valid);
        end
        d  = rsp_data;
        e  = rsp_err;
        id = rsp_id;
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        n_total++;
        if (req_ready !== 4'b0000) begin
            n_bad++; $display("FAIL reset_req_ready got=%b want=0000", req_ready);
        end
        n_total++;
        if ({rsp_valid, rsp_data, rsp_id, rsp_err, busy} !== 13'h0) begin
            n_bad++;
            $display("FAIL reset_outputs got v=%b d=%h id=%0d e=%b busy=%b want all 0",
                     rsp_valid, rsp_data, rsp_id, rsp_err, busy);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        rst_n     = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        @(negedge clk);
        req_op[3:0] = 4'd0;
        req_a[3:0]  = 4'd9;
        req_b[3:0]  = 4'd8;
        req_valid   = 4'b0001;
        rsp_ready   = 1'b1;
        #1;
        n_total++;
        if (req_ready !== 4'b0001) begin
            n_bad++; $display("FAIL single_grant got=%b want=0001", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        n_total++;
        if ({busy, rsp_valid} !== 2'b10) begin
            n_bad++; $display("FAIL single_exec got busy=%b v=%b want busy=1 v=0", busy, rsp_valid);
        end
        @(negedge clk);
        n_total++;
        if ({rsp_valid, rsp_data, rsp_id, rsp_err} !== {1'b1, 8'h11, 2'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL single_rsp got v=%b d=%h id=%0d e=%b want v=1 d=11 id=0 e=0",
                     rsp_valid, rsp_data, rsp_id, rsp_err);
        end
        @(negedge clk);
        n_total++;
        if ({rsp_valid, busy} !== 2'b00) begin
            n_bad++; $display("FAIL single_done got v=%b busy=%b want 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_arith();
        logic [3:0] t_op [15] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                                  4'd8, 4'd9, 4'd10, 4'd11, 4'd11, 4'd11, 4'd12};
        logic [3:0] t_a  [15] = '{4'h9, 4'h3, 4'hF, 4'hD, 4'hD, 4'hC, 4'hC, 4'hC,
                                  4'hC, 4'hC, 4'h1, 4'hF, 4'hF, 4'h3, 4'hC};
        logic [3:0] t_b  [15] = '{4'h8, 4'h5, 4'hF, 4'h4, 4'h4, 4'hA, 4'hA, 4'hA,
                                  4'hA, 4'h0, 4'hA, 4'h4, 4'h9, 4'h7, 4'h2};
        logic [7:0] t_d  [15] = '{8'h11, 8'hFE, 8'hE1, 8'h03, 8'h01, 8'h08, 8'h0E, 8'h06,
                                  8'h09, 8'h03, 8'h05, 8'hF0, 8'h00, 8'h80, 8'h03};
        logic [7:0] d;
        logic       e;
        logic [1:0] id;
        for (int k = 0; k < 15; k++) begin
            issue(k % 4, t_op[k], t_a[k], t_b[k], d, e, id);
            n_total++;
            if ({d, e, id} !== {t_d[k], 1'b0, 2'(k % 4)}) begin
                n_bad++;
                $display("FAIL arith_op%0d got d=%h e=%b id=%0d want d=%h e=0 id=%0d",
                         t_op[k], d, e, id, t_d[k], k % 4);
            end
        end
    endtask

    task automatic test_errors();
        logic [3:0] t_op [5] = '{4'd3, 4'd4, 4'd13, 4'd14, 4'd15};
        logic [3:0] t_a  [5] = '{4'd7, 4'd5, 4'd2, 4'd2, 4'd9};
        logic [3:0] t_b  [5] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd3};
        logic [7:0] d;
        logic       e;
        logic [1:0] id;
        for (int k = 0; k < 5; k++) begin
            issue(3, t_op[k], t_a[k], t_b[k], d, e, id);
            n_total++;
            if ({d, e, id} !== {8'h00, 1'b1, 2'd3}) begin
                n_bad++;
                $display("FAIL error_op%0d got d=%h e=%b id=%0d want d=00 e=1 id=3",
                         t_op[k], d, e, id);
            end
        end
    endtask

    task automatic test_round_robin();
        int n;
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            req_op[4*i +: 4] = 4'd0;
            req_a[4*i +: 4]  = 4'(i);
            req_b[4*i +: 4]  = 4'(2 * i);
        end
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        for (int g = 0; g < 5; g++) begin
            n = 0;
            while (req_ready == 4'b0000 && n < 10) begin @(negedge clk); n++; end
            n_total++;
            if (req_ready !== 4'(1 << (g % 4)) || (g > 0 && n != 0)) begin
                n_bad++;
                $display("FAIL rr_grant%0d got req_ready=%b wait=%0d want=%b wait=0",
                         g, req_ready, n, 4'(1 << (g % 4)));
            end
            @(negedge clk);
            @(negedge clk);
            n_total++;
            if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'(g % 4), 8'(3 * (g % 4))}) begin
                n_bad++;
                $display("FAIL rr_rsp%0d got v=%b id=%0d d=%h want v=1 id=%0d d=%h",
                         g, rsp_valid, rsp_id, rsp_data, g % 4, 8'(3 * (g % 4)));
            end
            @(negedge clk);
        end
        req_valid = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        pulse_reset();
        req_op[11:8] = 4'd7;
        req_a[11:8]  = 4'hA;
        req_b[11:8]  = 4'h3;
        req_op[3:0]  = 4'd0;
        req_a[3:0]   = 4'd1;
        req_b[3:0]   = 4'd1;
        rsp_ready    = 1'b0;
        req_valid    = 4'b0100;
        #1;
        n_total++;
        if (req_ready !== 4'b0100) begin
            n_bad++; $display("FAIL bp_grant got=%b want=0100", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0101;
        #1;
        n_total++;
        if (req_ready !== 4'b0000) begin
            n_bad++; $display("FAIL bp_exec_ready got=%b want=0000", req_ready);
        end
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            n_total++;
            if ({rsp_valid, rsp_data, rsp_err, rsp_id, req_ready} !==
                {1'b1, 8'h09, 1'b0, 2'd2, 4'b0000}) begin
                n_bad++;
                $display("FAIL bp_hold%0d got v=%b d=%h e=%b id=%0d rr=%b want v=1 d=09 e=0 id=2 rr=0000",
                         c, rsp_valid, rsp_data, rsp_err, rsp_id, req_ready);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        n_total++;
        if ({rsp_valid, req_ready} !== {1'b0, 4'b0001}) begin
            n_bad++;
            $display("FAIL bp_resume got v=%b req_ready=%b want v=0 req_ready=0001",
                     rsp_valid, req_ready);
        end
        req_valid = 4'b0000;
        @(negedge clk);
        n_total++;
        if ({busy, rsp_valid, req_ready} !== 6'b0) begin
            n_bad++;
            $display("FAIL drop_not_taken got busy=%b v=%b req_ready=%b want all 0",
                     busy, rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        @(negedge clk);
        req_op[7:4] = 4'd0;
        req_a[7:4]  = 4'd1;
        req_b[7:4]  = 4'd1;
        req_valid   = 4'b0010;
        rsp_ready   = 1'b1;
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 4'b1000;
        #1;
        n_total++;
        if ({req_ready, busy} !== 5'b0) begin
            n_bad++;
            $display("FAIL rstmid_in_reset got req_ready=%b busy=%b want 0000 0", req_ready, busy);
        end
        seen = 1'b0;
        @(negedge clk);
        seen = seen | rsp_valid;
        rst_n     = 1'b1;
        req_valid = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            seen = seen | rsp_valid;
        end
        n_total++;
        if (seen !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_no_rsp got rsp_valid seen=%b want 0", seen);
        end
        req_valid = 4'b1111;
        #1;
        n_total++;
        if (req_ready !== 4'b0001) begin
            n_bad++; $display("FAIL rstmid_rr_ptr got req_ready=%b want 0001", req_ready);
        end
        req_valid = 4'b0000;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid = 4'b0000;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        test_reset();
        test_single();
        test_arith();
        test_errors();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
